nec_uart_reporter: RTL and testbench

- Sequencer that turns decoded NEC receiver events into short ASCII messages and feeds them byte-by-byte to the UART transmitter (uart_tx).
- Arbitrates between two request sources: full NEC frames and NEC repeat codes. Each source has a one-deep pending slot, and frames take priority.
- Drives the transmitter's one-cycle valid strobe and waits for its one-cycle done pulse before issuing the next byte.

---
 rtl/nec_uart_reporter_if.sv | 11 +
 rtl/nec_uart_reporter.sv | 170 +++++++++++++++++
 tb/tb_nec_uart_reporter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nec_uart_reporter_if.sv
// Byte-stream handshake between the message sequencer and the UART transmitter.
// The sequencer pulses tx_valid for one cycle with tx_data, then holds tx_data
// until the transmitter answers with a one-cycle tx_done.
interface nec_uart_reporter_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (output tx_valid, output tx_data, input tx_done);
  modport slave  (input tx_valid, input tx_data, output tx_done);
endinterface

// File: rtl/nec_uart_reporter.sv
// Turns decoded NEC events into short ASCII messages and feeds them, one byte
// at a time, to the UART transmitter. Frames and repeat codes each have a
// one-deep pending slot; a pending frame is always served before a repeat.
module nec_uart_reporter #(
  parameter bit HEX_UPPER = 1'b1,
  parameter bit SEND_CRLF = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_valid,
  input  logic [31:0]                frame_data,
  input  logic                       repeat_valid,
  input  logic                       clr_ovf,
  nec_uart_reporter_if.master        tx,
  output logic                       busy,
  output logic                       overflow,
  output logic [7:0]                 msg_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, DONE} state_t;
  typedef enum logic [1:0] {K_REP, K_OK, K_ERR} kind_t;

  state_t      state;
  logic        pend_f;
  logic        pend_r;
  logic [31:0] frame_q;
  logic [31:0] word_q;
  logic        sel_frame;
  logic [3:0]  idx;
  logic [3:0]  len;
  kind_t       kind;
  logic [3:0]  body_len;
  logic        consume_f;
  logic        consume_r;
  logic        overwrite;

  // ASCII hex digit for one nibble; letter case chosen at elaboration.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] base;
    base = HEX_UPPER ? 8'h41 : 8'h61;
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = base + {4'h0, n - 4'd10};
  endfunction

  // Byte i of the message for kind k built from word w. Positions past the
  // body are the CR/LF terminator (only reached when SEND_CRLF is set).
  function automatic logic [7:0] msg_byte(input kind_t k, input logic [31:0] w,
                                          input logic [3:0] i);
    logic [3:0]  body;
    logic [3:0]  nib;
    logic [31:0] sh;
    body = (k == K_REP) ? 4'd1 : ((k == K_OK) ? 4'd5 : 4'd9);
    nib  = 4'h0;
    sh   = w << {i - 4'd1, 2'b00};
    if (i == 4'd0) begin
      msg_byte = (k == K_REP) ? 8'h52 : ((k == K_OK) ? 8'h46 : 8'h45);
    end else if (i < body) begin
      if (k == K_OK) begin
        case (i)
          4'd1:    nib = w[31:28];
          4'd2:    nib = w[27:24];
          4'd3:    nib = w[15:12];
          default: nib = w[11:8];
        endcase
      end else begin
        nib = sh[31:28];
      end
      msg_byte = hex_char(nib);
    end else begin
      msg_byte = (i == body) ? 8'h0D : 8'h0A;
    end
  endfunction

  // Message kind and body length follow from the word selected in IDLE.
  always_comb begin
    kind = K_REP;
    if (sel_frame) begin
      if (((word_q[31:24] ^ word_q[23:16]) == 8'hFF) &&
          ((word_q[15:8] ^ word_q[7:0]) == 8'hFF))
        kind = K_OK;
      else
        kind = K_ERR;
    end
    case (kind)
      K_OK:    body_len = 4'd5;
      K_ERR:   body_len = 4'd9;
      default: body_len = 4'd1;
    endcase
  end

  assign consume_f = (state == IDLE) && pend_f;
  assign consume_r = (state == IDLE) && !pend_f && pend_r;
  // A strobe landing on a slot that is not being drained this cycle loses data.
  assign overwrite = (frame_valid && pend_f && !consume_f) ||
                     (repeat_valid && pend_r && !consume_r);

  // Frame slot payload; always holds the most recent strobe's data.
  always_ff @(posedge clk) begin
    if (frame_valid) frame_q <= frame_data;
  end

  // Pending slots, overflow flag and the message sequencer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      pend_f      <= 1'b0;
      pend_r      <= 1'b0;
      sel_frame   <= 1'b0;
      tx.tx_valid <= 1'b0;
      tx.tx_data  <= 8'h00;
      busy        <= 1'b0;
      overflow    <= 1'b0;
      msg_count   <= 8'h00;
    end else begin
      tx.tx_valid <= 1'b0;

      if (frame_valid)    pend_f <= 1'b1;
      else if (consume_f) pend_f <= 1'b0;

      if (repeat_valid)   pend_r <= 1'b1;
      else if (consume_r) pend_r <= 1'b0;

      if (overwrite)      overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;

      case (state)
        IDLE: begin
          if (consume_f) begin
            sel_frame <= 1'b1;
            word_q    <= frame_q;
            state     <= LOAD;
          end else if (consume_r) begin
            sel_frame <= 1'b0;
            state     <= LOAD;
          end
        end
        LOAD: begin
          len         <= body_len + (SEND_CRLF ? 4'd2 : 4'd0);
          idx         <= 4'd0;
          busy        <= 1'b1;
          tx.tx_valid <= 1'b1;
          tx.tx_data  <= msg_byte(kind, word_q, 4'd0);
          state       <= SEND;
        end
        SEND: begin
          state <= WAIT;
        end
        WAIT: begin
          if (tx.tx_done) begin
            if (idx == len - 4'd1) begin
              state <= DONE;
            end else begin
              idx         <= idx + 4'd1;
              tx.tx_valid <= 1'b1;
              tx.tx_data  <= msg_byte(kind, word_q, idx + 4'd1);
              state       <= SEND;
            end
          end
        end
        DONE: begin
          msg_count <= msg_count + 8'd1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nec_uart_reporter.sv
// Bench for nec_uart_reporter: two instances (uppercase+CRLF, lowercase without
// terminator) share the stimulus; each has its own UART model and byte capture.
module tb_nec_uart_reporter;

  logic        clk;
  logic        rst;
  logic        frame_valid;
  logic [31:0] frame_data;
  logic        repeat_valid;
  logic        clr_ovf;
  logic        busy0, ovf0, busy1, ovf1;
  logic [7:0]  mc0, mc1;
  logic        done0, done1, stray;
  int          cnt0, cnt1;
  int          cyc;
  int          strobe_cyc;
  int          n_cmp;
  int          n_bad;
  logic [7:0]  exp_cnt;
  logic [7:0]  cap0[$];
  logic [7:0]  cap1[$];
  int          txv_cyc0[$];

  nec_uart_reporter_if ifc0();
  nec_uart_reporter_if ifc1();

  nec_uart_reporter #(.HEX_UPPER(1'b1), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .repeat_valid(repeat_valid), .clr_ovf(clr_ovf), .tx(ifc0),
    .busy(busy0), .overflow(ovf0), .msg_count(mc0)
  );

  nec_uart_reporter #(.HEX_UPPER(1'b0), .SEND_CRLF(1'b0)) dut_lc (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .repeat_valid(repeat_valid), .clr_ovf(clr_ovf), .tx(ifc1),
    .busy(busy1), .overflow(ovf1), .msg_count(mc1)
  );

  assign ifc0.tx_done = done0 | stray;
  assign ifc1.tx_done = done1 | stray;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART models: tx_done pulses a fixed number of cycles after each tx_valid.
  always @(posedge clk) begin
    if (!rst) begin
      cnt0 <= 0; cnt1 <= 0; done0 <= 1'b0; done1 <= 1'b0;
    end else begin
      done0 <= (cnt0 == 1);
      done1 <= (cnt1 == 1);
      if (ifc0.tx_valid) cnt0 <= 10; else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      if (ifc1.tx_valid) cnt1 <= 10; else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
  end

  // Capture every transmitted byte and the cycle of each start strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_valid) strobe_cyc <= cyc;
    if (ifc0.tx_valid) begin
      cap0.push_back(ifc0.tx_data);
      txv_cyc0.push_back(cyc);
    end
    if (ifc1.tx_valid) cap1.push_back(ifc1.tx_data);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic string crlf(input string s);
    return $sformatf("%s%c%c", s, 8'h0D, 8'h0A);
  endfunction

  // Reference message: built from the message rules with string formatting.
  function automatic string model_msg(input bit is_rep, input logic [31:0] w,
                                      input bit upper, input bit term);
    string s;
    string digits;
    if (is_rep) begin
      s = "R";
    end else begin
      if (((w[31:24] ^ w[23:16]) == 8'hFF) && ((w[15:8] ^ w[7:0]) == 8'hFF)) begin
        digits = $sformatf("%02h%02h", w[31:24], w[15:8]);
        if (upper) digits = digits.toupper();
        s = {"F", digits};
      end else begin
        digits = $sformatf("%08h", w);
        if (upper) digits = digits.toupper();
        s = {"E", digits};
      end
    end
    if (term) s = crlf(s);
    return s;
  endfunction

  task automatic strobe(input bit f, input logic [31:0] d, input bit r, input bit c);
    frame_valid = f; frame_data = d; repeat_valid = r; clr_ovf = c;
    @(posedge clk); #1;
    frame_valid = 1'b0; repeat_valid = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_both(input logic [7:0] target, input int budget);
    int n;
    n = 0;
    while ((mc0 !== target || mc1 !== target) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("msg_count_main", {24'h0, mc0}, {24'h0, target});
    chk("msg_count_lc", {24'h0, mc1}, {24'h0, target});
  endtask

  task automatic chk_stream(input int id, input string exp);
    logic [7:0] q[$];
    if (id == 0) begin q = cap0; cap0.delete(); end
    else         begin q = cap1; cap1.delete(); end
    chk($sformatf("stream_len_%0d", id), q.size(), exp.len());
    for (int i = 0; i < q.size() && i < exp.len(); i++)
      chk($sformatf("stream%0d_byte%0d", id, i), {24'h0, q[i]}, {24'h0, exp[i]});
  endtask

  typedef struct {
    bit          is_rep;
    logic [31:0] data;
    string       exp0;
    string       exp1;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 32'h00FF45BA, "F0045",     "F0045"};
    vecs[1] = '{1'b0, 32'h12345678, "E12345678", "E12345678"};
    vecs[2] = '{1'b0, 32'hABCDEF01, "EABCDEF01", "Eabcdef01"};
    vecs[3] = '{1'b1, 32'h00000000, "R",         "R"};
    vecs[4] = '{1'b0, 32'h5AA5C33C, "F5AC3",     "F5ac3"};
    vecs[5] = '{1'b0, 32'hFF00A55A, "FFFA5",     "Fffa5"};
    vecs[6] = '{1'b0, 32'h00000000, "E00000000", "E00000000"};

    n_cmp = 0; n_bad = 0; cyc = 0; exp_cnt = 8'h00;
    rst = 1'b0; frame_valid = 1'b0; frame_data = 32'h0;
    repeat_valid = 1'b0; clr_ovf = 1'b0; stray = 1'b0;

    // Reset state
    idle_cycles(3);
    chk("rst_tx_valid", {31'h0, ifc0.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, ifc0.tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy0}, 32'h0);
    chk("rst_overflow", {31'h0, ovf0}, 32'h0);
    chk("rst_msg_count", {24'h0, mc0}, 32'h0);
    rst = 1'b1;
    idle_cycles(2);

    // First frame: latency, pulse count, content
    txv_cyc0.delete();
    strobe(1'b1, 32'h00FF45BA, 1'b0, 1'b0);
    exp_cnt++;
    wait_both(exp_cnt, 400);
    chk("first_pulse_latency", txv_cyc0.size() > 0 ? txv_cyc0[0] - strobe_cyc : -1, 3);
    chk("pulse_count", txv_cyc0.size(), 7);
    chk("busy_after_msg", {31'h0, busy0}, 32'h0);
    chk_stream(0, crlf("F0045"));
    chk_stream(1, "F0045");

    // Table-driven messages
    for (int i = 0; i < 7; i++) begin
      strobe(!vecs[i].is_rep, vecs[i].data, vecs[i].is_rep, 1'b0);
      exp_cnt++;
      wait_both(exp_cnt, 400);
      chk_stream(0, crlf(vecs[i].exp0));
      chk_stream(1, vecs[i].exp1);
    end

    // Frame and repeat in the same cycle: frame first, no overflow
    strobe(1'b1, 32'h20DF10EF, 1'b1, 1'b0);
    exp_cnt += 8'd2;
    wait_both(exp_cnt, 600);
    chk_stream(0, {crlf("F2010"), crlf("R")});
    chk_stream(1, "F2010R");
    chk("same_cycle_ovf", {31'h0, ovf0}, 32'h0);

    // Overwrite of a pending frame during a busy message
    strobe(1'b1, 32'h00FF45BA, 1'b0, 1'b0);
    idle_cycles(5);
    strobe(1'b1, 32'h00FF10EF, 1'b0, 1'b0);
    chk("ovf_after_first_pending", {31'h0, ovf0}, 32'h0);
    strobe(1'b1, 32'h00FF20DF, 1'b0, 1'b0);
    chk("ovf_after_overwrite", {31'h0, ovf0}, 32'h1);
    chk("ovf_after_overwrite_lc", {31'h0, ovf1}, 32'h1);
    exp_cnt += 8'd2;
    wait_both(exp_cnt, 800);
    chk_stream(0, {crlf("F0045"), crlf("F0020")});
    chk_stream(1, "F0045F0020");
    chk("ovf_sticky", {31'h0, ovf0}, 32'h1);
    strobe(1'b0, 32'h0, 1'b0, 1'b1);
    chk("ovf_cleared", {31'h0, ovf0}, 32'h0);

    // clr_ovf in the same cycle as an overwrite: set wins
    strobe(1'b1, 32'h00FF45BA, 1'b0, 1'b0);
    idle_cycles(5);
    strobe(1'b1, 32'h00FF10EF, 1'b0, 1'b0);
    strobe(1'b1, 32'h00FF30CF, 1'b0, 1'b1);
    chk("ovf_set_beats_clear", {31'h0, ovf0}, 32'h1);
    exp_cnt += 8'd2;
    wait_both(exp_cnt, 800);
    chk_stream(0, {crlf("F0045"), crlf("F0030")});
    chk_stream(1, "F0045F0030");
    strobe(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized messages against the reference model
    for (int i = 0; i < 20; i++) begin
      int          sel;
      logic [7:0]  a, c;
      logic [31:0] w;
      sel = $urandom_range(0, 2);
      a = 8'($urandom);
      c = 8'($urandom);
      w = (sel == 1) ? {a, ~a, c, ~c} : $urandom;
      strobe(sel != 0, w, sel == 0, 1'b0);
      exp_cnt++;
      wait_both(exp_cnt, 400);
      chk_stream(0, model_msg(sel == 0, w, 1'b1, 1'b1));
      chk_stream(1, model_msg(sel == 0, w, 1'b0, 1'b0));
    end

    // Reset in the middle of a message, with a repeat pending
    strobe(1'b1, 32'h12345678, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (cap0.size() < 3 && n < 200) begin @(posedge clk); #1; n++; end
      chk("reached_byte3", {31'h0, cap0.size() >= 3}, 32'h1);
    end
    idle_cycles(3);
    strobe(1'b0, 32'h0, 1'b1, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tx_valid", {31'h0, ifc0.tx_valid}, 32'h0);
    chk("midrst_tx_data", {24'h0, ifc0.tx_data}, 32'h0);
    chk("midrst_busy", {31'h0, busy0}, 32'h0);
    chk("midrst_msg_count", {24'h0, mc0}, 32'h0);
    rst = 1'b1;
    cap0.delete(); cap1.delete();
    idle_cycles(1);
    stray = 1'b1;
    idle_cycles(1);
    stray = 1'b0;
    idle_cycles(40);
    chk("postrst_no_bytes", cap0.size(), 0);
    chk("postrst_no_bytes_lc", cap1.size(), 0);
    chk("postrst_busy", {31'h0, busy0}, 32'h0);
    chk("postrst_msg_count", {24'h0, mc0}, 32'h0);
    exp_cnt = 8'h00;

    // 256 repeats wrap the message counter
    for (int i = 0; i < 256; i++) begin
      strobe(1'b0, 32'h0, 1'b1, 1'b0);
      exp_cnt++;
      wait_both(exp_cnt, 200);
      chk_stream(0, crlf("R"));
      chk_stream(1, "R");
    end
    chk("wrap_msg_count", {24'h0, mc0}, 32'h0);
    chk("wrap_ovf", {31'h0, ovf0}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
